// File: rtl/alu_pkg.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module      : alu_pkg
// Description : Shared types and constants for the ALU issue front end:
//               opcode enum, operand/opcode widths and issue FSM states.
// Revision    : 1.0 - initial release
// ============================================================================
package alu_pkg;

    localparam int ALU_W     = 4;
    localparam int ALU_SEL_W = 3;
    // One buffered command: {a, b, sel}
    localparam int CMD_W     = 2*ALU_W + ALU_SEL_W;

    typedef enum logic [ALU_SEL_W-1:0] {
        ADD = 3'b000,
        SUB = 3'b001,
        AND = 3'b010,
        OR  = 3'b011,
        XOR = 3'b100
    } alu_op_t;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_EXEC = 2'd1,
        ST_RESP = 2'd2
    } alu_issue_state_t;

    // Opcodes above XOR have no defined ALU function
    function automatic logic sel_is_legal(input logic [ALU_SEL_W-1:0] sel);
        return (sel <= XOR);
    endfunction

endpackage
`default_nettype wire

// File: rtl/alu_cmd_fifo.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module      : alu_cmd_fifo
// Description : Synchronous command FIFO. Push is ignored when full and pop
//               when empty; a push into an empty FIFO is readable next cycle.
// Revision    : 1.0 - initial release
// ============================================================================
module alu_cmd_fifo #(
    parameter int WIDTH = 11,
    parameter int DEPTH = 4
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             push,
    input  logic [WIDTH-1:0] push_data,
    input  logic             pop,
    output logic [WIDTH-1:0] pop_data,
    output logic             full,
    output logic             empty
);

    localparam int ADDR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;

    logic [WIDTH-1:0]  mem_q [DEPTH];
    logic [ADDR_W-1:0] wr_ptr_q, wr_ptr_d;
    logic [ADDR_W-1:0] rd_ptr_q, rd_ptr_d;
    logic [DEPTH:0]    count_q, count_d;
    logic              w_do_push;
    logic              w_do_pop;

    assign full      = (count_q == (DEPTH+1)'(DEPTH));
    assign empty     = (count_q == '0);
    assign w_do_push = push && !full;
    assign w_do_pop  = pop && !empty;
    assign pop_data  = mem_q[rd_ptr_q];

    // Pointer and occupancy update; pointers wrap naturally at DEPTH
    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (w_do_push) wr_ptr_d = wr_ptr_q + ADDR_W'(1);
        if (w_do_pop)  rd_ptr_d = rd_ptr_q + ADDR_W'(1);
        unique case ({w_do_push, w_do_pop})
            2'b10:   count_d = count_q + (DEPTH+1)'(1);
            2'b01:   count_d = count_q - (DEPTH+1)'(1);
            default: count_d = count_q;
        endcase
    end

    // Pointer and count registers
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

    // Storage array; contents need no reset since occupancy gates reads
    always_ff @(posedge clk) begin
        if (w_do_push) mem_q[wr_ptr_q] <= push_data;
    end

endmodule
`default_nettype wire

// File: rtl/alu_issue_ctrl.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module      : alu_issue_ctrl
// Description : Buffers ALU commands, issues them one at a time on registered
//               operand/opcode outputs and returns the captured result on a
//               valid/ready response port.
//               Optional macro ALU_ISSUE_ILLEGAL_CHECK_EN flags opcodes
//               101..111 through rsp_err and forces a zero result.
// Revision    : 1.0 - initial release
// ============================================================================
module alu_issue_ctrl
    import alu_pkg::*;
#(
    parameter int DEPTH = 4
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 cmd_valid,
    output logic                 cmd_ready,
    input  logic [ALU_W-1:0]     cmd_a,
    input  logic [ALU_W-1:0]     cmd_b,
    input  logic [ALU_SEL_W-1:0] cmd_sel,
    output logic [ALU_W-1:0]     alu_a,
    output logic [ALU_W-1:0]     alu_b,
    output logic [ALU_SEL_W-1:0] alu_sel,
    input  logic [ALU_W-1:0]     alu_out,
    input  logic                 alu_carry,
    output logic                 rsp_valid,
    input  logic                 rsp_ready,
    output logic [ALU_W-1:0]     rsp_data,
    output logic                 rsp_carry,
    output logic                 rsp_zero,
    output logic                 rsp_err
);

    alu_issue_state_t       state_q, state_d;
    logic [ALU_W-1:0]       alu_a_q, alu_a_d;
    logic [ALU_W-1:0]       alu_b_q, alu_b_d;
    logic [ALU_SEL_W-1:0]   alu_sel_q, alu_sel_d;
    logic                   rsp_valid_q, rsp_valid_d;
    logic [ALU_W-1:0]       rsp_data_q, rsp_data_d;
    logic                   rsp_carry_q, rsp_carry_d;
    logic                   rsp_zero_q, rsp_zero_d;
`ifdef ALU_ISSUE_ILLEGAL_CHECK_EN
    logic                   rsp_err_q, rsp_err_d;
`endif

    logic                   w_fifo_pop;
    logic                   w_fifo_full;
    logic                   w_fifo_empty;
    logic [CMD_W-1:0]       w_fifo_head;

    // cmd_ready depends on registered FIFO state only, so no push when full
    assign cmd_ready = !w_fifo_full;

    alu_cmd_fifo #(
        .WIDTH (CMD_W),
        .DEPTH (DEPTH)
    ) u_cmd_fifo (
        .clk       (clk),
        .rst_n     (rst_n),
        .push      (cmd_valid && cmd_ready),
        .push_data ({cmd_a, cmd_b, cmd_sel}),
        .pop       (w_fifo_pop),
        .pop_data  (w_fifo_head),
        .full      (w_fifo_full),
        .empty     (w_fifo_empty)
    );

    // Issue FSM: pop/load in IDLE or on response acceptance, capture in EXEC
    always_comb begin
        state_d     = state_q;
        alu_a_d     = alu_a_q;
        alu_b_d     = alu_b_q;
        alu_sel_d   = alu_sel_q;
        rsp_valid_d = rsp_valid_q;
        rsp_data_d  = rsp_data_q;
        rsp_carry_d = rsp_carry_q;
        rsp_zero_d  = rsp_zero_q;
`ifdef ALU_ISSUE_ILLEGAL_CHECK_EN
        rsp_err_d   = rsp_err_q;
`endif
        w_fifo_pop  = 1'b0;
        unique case (state_q)
            ST_IDLE: begin
                if (!w_fifo_empty) begin
                    w_fifo_pop                      = 1'b1;
                    {alu_a_d, alu_b_d, alu_sel_d}   = w_fifo_head;
                    state_d                         = ST_EXEC;
                end
            end
            ST_EXEC: begin
                rsp_valid_d = 1'b1;
                rsp_data_d  = alu_out;
                rsp_carry_d = alu_carry;
                rsp_zero_d  = (alu_out == '0);
`ifdef ALU_ISSUE_ILLEGAL_CHECK_EN
                rsp_err_d   = 1'b0;
                if (!sel_is_legal(alu_sel_q)) begin
                    rsp_err_d   = 1'b1;
                    rsp_data_d  = '0;
                    rsp_carry_d = 1'b0;
                    rsp_zero_d  = 1'b1;
                end
`endif
                state_d     = ST_RESP;
            end
            ST_RESP: begin
                if (rsp_ready) begin
                    rsp_valid_d = 1'b0;
                    if (!w_fifo_empty) begin
                        w_fifo_pop                    = 1'b1;
                        {alu_a_d, alu_b_d, alu_sel_d} = w_fifo_head;
                        state_d                       = ST_EXEC;
                    end else begin
                        state_d = ST_IDLE;
                    end
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    // State, issue and response registers
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= ST_IDLE;
            alu_a_q     <= '0;
            alu_b_q     <= '0;
            alu_sel_q   <= '0;
            rsp_valid_q <= 1'b0;
            rsp_data_q  <= '0;
            rsp_carry_q <= 1'b0;
            rsp_zero_q  <= 1'b0;
`ifdef ALU_ISSUE_ILLEGAL_CHECK_EN
            rsp_err_q   <= 1'b0;
`endif
        end else begin
            state_q     <= state_d;
            alu_a_q     <= alu_a_d;
            alu_b_q     <= alu_b_d;
            alu_sel_q   <= alu_sel_d;
            rsp_valid_q <= rsp_valid_d;
            rsp_data_q  <= rsp_data_d;
            rsp_carry_q <= rsp_carry_d;
            rsp_zero_q  <= rsp_zero_d;
`ifdef ALU_ISSUE_ILLEGAL_CHECK_EN
            rsp_err_q   <= rsp_err_d;
`endif
        end
    end

    assign alu_a     = alu_a_q;
    assign alu_b     = alu_b_q;
    assign alu_sel   = alu_sel_q;
    assign rsp_valid = rsp_valid_q;
    assign rsp_data  = rsp_data_q;
    assign rsp_carry = rsp_carry_q;
    assign rsp_zero  = rsp_zero_q;
`ifdef ALU_ISSUE_ILLEGAL_CHECK_EN
    assign rsp_err   = rsp_err_q;
`else
    assign rsp_err   = 1'b0;
`endif

endmodule
`default_nettype wire

// File: tb/tb_alu_issue_ctrl.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module      : tb_alu_issue_ctrl
// Description : Self-checking bench for alu_issue_ctrl with a behavioural ALU,
//               a queue-based response scoreboard, table vectors and
//               directed backpressure / wrap / reset sequences.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_alu_issue_ctrl;
    import alu_pkg::*;

    localparam int DEPTH = 4;
`ifdef ALU_ISSUE_ILLEGAL_CHECK_EN
    localparam logic ILLEGAL_ERR = 1'b1;
`else
    localparam logic ILLEGAL_ERR = 1'b0;
`endif

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       cmd_valid, cmd_ready;
    logic [3:0] cmd_a, cmd_b;
    logic [2:0] cmd_sel;
    logic [3:0] alu_a, alu_b, alu_out;
    logic [2:0] alu_sel;
    logic       alu_carry;
    logic       rsp_valid, rsp_ready;
    logic [3:0] rsp_data;
    logic       rsp_carry, rsp_zero, rsp_err;

    int n_checks = 0;
    int n_pass   = 0;

    always #5 clk = ~clk;

    alu_issue_ctrl #(.DEPTH(DEPTH)) dut (
        .clk(clk), .rst_n(rst_n),
        .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
        .cmd_a(cmd_a), .cmd_b(cmd_b), .cmd_sel(cmd_sel),
        .alu_a(alu_a), .alu_b(alu_b), .alu_sel(alu_sel),
        .alu_out(alu_out), .alu_carry(alu_carry),
        .rsp_valid(rsp_valid), .rsp_ready(rsp_ready),
        .rsp_data(rsp_data), .rsp_carry(rsp_carry),
        .rsp_zero(rsp_zero), .rsp_err(rsp_err)
    );

    // Behavioural 4-bit ALU: {carry, result}; undefined opcodes give 0
    function automatic logic [4:0] alu_fn(input logic [3:0] a, input logic [3:0] b,
                                          input logic [2:0] sel);
        case (sel)
            3'd0:    return {1'b0, a} + {1'b0, b};
            3'd1:    return {1'b0, a} - {1'b0, b};
            3'd2:    return {1'b0, a & b};
            3'd3:    return {1'b0, a | b};
            3'd4:    return {1'b0, a ^ b};
            default: return 5'd0;
        endcase
    endfunction

    assign {alu_carry, alu_out} = alu_fn(alu_a, alu_b, alu_sel);

    // Expected response {err, zero, carry, data} for one command
    function automatic logic [6:0] ref_rsp(input logic [3:0] a, input logic [3:0] b,
                                           input logic [2:0] sel);
        logic [4:0] r;
        r = alu_fn(a, b, sel);
        if (sel > 3'd4 && ILLEGAL_ERR) return 7'b110_0000;
        return {1'b0, (r[3:0] == 4'd0), r[4], r[3:0]};
    endfunction

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h expected 0x%0h", name, got, exp);
    endtask

    // Scoreboard: every accepted command queues its expected response
    logic [6:0] exp_q[$];
    logic       hold_prev = 1'b0;
    logic [6:0] prev_rsp  = '0;

    always @(negedge clk) begin
        if (!rst_n) begin
            exp_q.delete();
            hold_prev = 1'b0;
        end else begin
            if (hold_prev) begin
                check("rsp_hold_valid", rsp_valid, 1);
                check("rsp_hold_data", {rsp_err, rsp_zero, rsp_carry, rsp_data}, prev_rsp);
            end
            if (rsp_valid && rsp_ready) begin
                if (exp_q.size() == 0) begin
                    n_checks++;
                    $display("FAIL rsp_spurious: got rsp 0x%0h expected no response",
                             {rsp_err, rsp_zero, rsp_carry, rsp_data});
                end else begin
                    check("rsp_order", {rsp_err, rsp_zero, rsp_carry, rsp_data}, exp_q.pop_front());
                end
            end
            hold_prev = rsp_valid && !rsp_ready;
            prev_rsp  = {rsp_err, rsp_zero, rsp_carry, rsp_data};
            if (cmd_valid && cmd_ready) exp_q.push_back(ref_rsp(cmd_a, cmd_b, cmd_sel));
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Offer n commands {a=base+k, b=3k+1, sel} for at most max_cyc cycles
    task automatic push_n(input int n, input int base, input logic [2:0] sel,
                          input int max_cyc, output int accepted);
        accepted = 0;
        for (int c = 0; c < max_cyc; c++) begin
            cmd_valid = (accepted < n);
            cmd_a     = 4'(base + accepted);
            cmd_b     = 4'(3 * accepted + 1);
            cmd_sel   = sel;
            @(negedge clk);
            if (cmd_valid && cmd_ready) accepted++;
            step();
        end
        cmd_valid = 1'b0;
    endtask

    typedef struct {
        logic [3:0] a;
        logic [3:0] b;
        logic [2:0] sel;
        logic [6:0] exp;   // {err, zero, carry, data}
    } vec_t;

    vec_t vecs[8];

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin
        int acc;
        int n_rsp;
        int last;
        int seen;

        vecs[0] = '{4'h9, 4'h8, 3'b000, 7'b001_0001};   // 9+8 = 0x11
        vecs[1] = '{4'h3, 4'h5, 3'b001, 7'b001_1110};   // 3-5 borrow
        vecs[2] = '{4'hA, 4'hA, 3'b100, 7'b010_0000};   // xor to zero
        vecs[3] = '{4'hC, 4'h3, 3'b010, 7'b010_0000};   // and to zero
        vecs[4] = '{4'h5, 4'hA, 3'b011, 7'b000_1111};   // or
        vecs[5] = '{4'h7, 4'h7, 3'b001, 7'b010_0000};   // 7-7, no borrow
        vecs[6] = '{4'hF, 4'h1, 3'b000, 7'b011_0000};   // overflow to zero
        vecs[7] = '{4'h3, 4'h4, 3'b110, {ILLEGAL_ERR, 6'b10_0000}};

        cmd_valid = 1'b0; cmd_a = '0; cmd_b = '0; cmd_sel = '0; rsp_ready = 1'b0;
        repeat (3) step();

        // Reset values
        check("rst_cmd_ready", cmd_ready, 1);
        check("rst_rsp", {rsp_valid, rsp_err, rsp_zero, rsp_carry, rsp_data}, 0);
        check("rst_alu", {alu_a, alu_b, alu_sel}, 0);
        rst_n = 1'b1;
        step();

        // Table vectors with latency checks
        for (int i = 0; i < 8; i++) begin
            rsp_ready = 1'b1;
            check($sformatf("vec%0d_ready", i), cmd_ready, 1);
            cmd_valid = 1'b1; cmd_a = vecs[i].a; cmd_b = vecs[i].b; cmd_sel = vecs[i].sel;
            step();                        // edge N: push
            cmd_valid = 1'b0;
            check($sformatf("vec%0d_lat0", i), rsp_valid, 0);
            step();                        // edge N+1: pop and load
            check($sformatf("vec%0d_lat1", i), rsp_valid, 0);
            check($sformatf("vec%0d_ops", i), {alu_a, alu_b, alu_sel},
                  {vecs[i].a, vecs[i].b, vecs[i].sel});
            step();                        // edge N+2: response
            check($sformatf("vec%0d_valid", i), rsp_valid, 1);
            check($sformatf("vec%0d_rsp", i), {rsp_err, rsp_zero, rsp_carry, rsp_data}, vecs[i].exp);
            step();
            check($sformatf("vec%0d_opshold", i), {alu_a, alu_b, alu_sel},
                  {vecs[i].a, vecs[i].b, vecs[i].sel});
            step();
        end

        // Backpressure: 6 offered, DEPTH+1 accepted, first response held
        rsp_ready = 1'b0;
        push_n(6, 0, 3'b000, 14, acc);
        check("bp_accepted", acc, DEPTH + 1);
        check("bp_cmd_ready", cmd_ready, 0);
        check("bp_first_valid", rsp_valid, 1);
        check("bp_first_rsp", {rsp_err, rsp_zero, rsp_carry, rsp_data}, ref_rsp(4'd0, 4'd1, 3'b000));
        rsp_ready = 1'b1;
        n_rsp = 0; last = 0;
        for (int c = 0; c < 30; c++) begin
            @(negedge clk);
            if (rsp_valid) begin
                if (n_rsp > 0) check("bp_rsp_gap", c - last, 2);
                last = c;
                n_rsp++;
            end
            step();
        end
        check("bp_drain_count", n_rsp, DEPTH + 1);

        // Simultaneous push/pop at DEPTH-1, across pointer wrap
        rsp_ready = 1'b0;
        push_n(4, 5, 3'b100, 6, acc);
        check("pp_accepted", acc, 4);
        for (int c = 0; c < 10 && !rsp_valid; c++) step();
        check("pp_wait_rsp", rsp_valid, 1);
        check("pp_ready_before", cmd_ready, 1);
        cmd_valid = 1'b1; cmd_a = 4'hE; cmd_b = 4'h1; cmd_sel = 3'b100; rsp_ready = 1'b1;
        step();
        cmd_valid = 1'b0; rsp_ready = 1'b0;
        check("pp_ready_after", cmd_ready, 1);
        cmd_valid = 1'b1; cmd_a = 4'h2; cmd_b = 4'h9; cmd_sel = 3'b001;
        step();
        cmd_valid = 1'b0;
        check("pp_full_after_one_more", cmd_ready, 0);
        rsp_ready = 1'b1;
        for (int c = 0; c < 40 && exp_q.size() > 0; c++) step();
        step();
        check("pp_drained", exp_q.size(), 0);

        // Reset while holding a response with three commands queued
        rsp_ready = 1'b0;
        push_n(4, 1, 3'b000, 6, acc);
        for (int c = 0; c < 10 && !rsp_valid; c++) step();
        check("mr_wait_rsp", rsp_valid, 1);
        @(negedge clk);
        #2 rst_n = 1'b0;
        #1;
        check("mr_cmd_ready", cmd_ready, 1);
        check("mr_rsp", {rsp_valid, rsp_err, rsp_zero, rsp_carry, rsp_data}, 0);
        check("mr_alu", {alu_a, alu_b, alu_sel}, 0);
        step(); step();
        rst_n = 1'b1;
        rsp_ready = 1'b1;
        seen = 0;
        for (int c = 0; c < 12; c++) begin
            @(negedge clk);
            if (rsp_valid) seen++;
            step();
        end
        check("mr_no_rsp", seen, 0);

        // Randomized traffic against the scoreboard
        for (int c = 0; c < 800; c++) begin
            cmd_valid = ($urandom_range(0, 9) < 6);
            cmd_a     = 4'($urandom);
            cmd_b     = 4'($urandom);
            cmd_sel   = 3'($urandom_range(0, 7));
            rsp_ready = 1'($urandom_range(0, 1));
            step();
        end
        cmd_valid = 1'b0;
        rsp_ready = 1'b1;
        for (int c = 0; c < 40 && exp_q.size() > 0; c++) step();
        step();
        check("rand_drained", exp_q.size(), 0);
        check("rand_idle_valid", rsp_valid, 0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
`default_nettype wire
